// File: rtl/interp_pkg.sv
// Shared constants for the interpolation chain: widths, frame timing, phase map and
// the odd-branch halfband coefficients of the Stage-2 filter.
package interp_pkg;

  localparam int DW          = 16;
  localparam int CW          = 16;
  localparam int NUNIQ       = 8;
  localparam int AW          = 36;
  localparam int FRAME_LEN   = 32;
  localparam int OUT_SPACING = 16;
  localparam int PH_W        = $clog2(FRAME_LEN);
  localparam int DL_LEN      = 2 * NUNIQ;
  localparam int CTR_TAP     = NUNIQ - 1;

  localparam logic [PH_W-1:0] PH_LOAD      = PH_W'(0);
  localparam logic [PH_W-1:0] PH_MAC_FIRST = PH_W'(1);
  localparam logic [PH_W-1:0] PH_MAC_LAST  = PH_W'(NUNIQ);
  localparam logic [PH_W-1:0] PH_ROUND     = PH_W'(NUNIQ + 1);
  localparam logic [PH_W-1:0] PH_OUT_A     = PH_W'(OUT_SPACING - 1);
  localparam logic [PH_W-1:0] PH_OUT_B     = PH_W'(FRAME_LEN - 1);

  // Q1.15 pairs; the eight values sum to 16384, so the mirrored 16-tap branch sums to 32768.
  localparam logic signed [CW-1:0] HB_COEF [NUNIQ] = '{
    -16'sd24, 16'sd74, -16'sd180, 16'sd376,
    -16'sd718, 16'sd1321, -16'sd2560, 16'sd18095
  };

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_MAC, ST_ROUND} phase_e;

  function automatic phase_e phase_of(input logic [PH_W-1:0] ph);
    if (ph == PH_LOAD) return ST_LOAD;
    if ((ph >= PH_MAC_FIRST) && (ph <= PH_MAC_LAST)) return ST_MAC;
    if (ph == PH_ROUND) return ST_ROUND;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/hb_mac.sv
// Serial symmetric MAC: pre-adds a mirrored tap pair, multiplies by one coefficient and
// accumulates; clr has priority over en.
module hb_mac
  import interp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [CW-1:0] coef,
  output logic signed [AW-1:0] acc
);

  logic signed [DW:0]    pre;
  logic signed [DW+CW:0] prod;
  logic signed [AW-1:0]  acc_d, acc_q;

  always_comb begin
    pre   = (DW+1)'(a) + (DW+1)'(b);
    prod  = pre * coef;
    acc_d = acc_q;
    if (clr) acc_d = '0;
    else if (en) acc_d = acc_q + AW'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/hb_interp2_stage2.sv
// Stage-2 halfband interpolate-by-2 FIR and chain timing master (100 kHz in, 200 kHz out).
// Define HB_SAT_EN to saturate the FIR result and add sat_flag; otherwise the result wraps.
module hb_interp2_stage2
  import interp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  output logic                 en_100k,
  output logic signed [DW-1:0] dout,
  output logic                 en_200k
`ifdef HB_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  localparam logic signed [AW-1:0] RND_HALF = AW'(16384);
`ifdef HB_SAT_EN
  localparam logic signed [AW-1:0] POS_LIM  = AW'(32767);
  localparam logic signed [AW-1:0] NEG_LIM  = ~POS_LIM;
`endif

  logic [PH_W-1:0]      ph_d, ph_q;
  logic signed [DW-1:0] dl_d [DL_LEN];
  logic signed [DW-1:0] dl_q [DL_LEN];
  logic signed [DW-1:0] res_d, res_q;
  logic signed [DW-1:0] dout_d, dout_q;
  logic                 en200_d, en200_q;
  logic [2:0]           tap;
  logic [3:0]           tap_mir;
  phase_e               st;
  logic signed [AW-1:0] acc;

  function automatic logic signed [AW-1:0] rnd_shift(input logic signed [AW-1:0] a);
    return (a + RND_HALF) >>> 15;
  endfunction

`ifdef HB_SAT_EN
  logic                 sat_d, sat_q;
  logic signed [AW-1:0] rnd;

  function automatic logic is_clip(input logic signed [AW-1:0] v);
    return (v > POS_LIM) || (v < NEG_LIM);
  endfunction

  function automatic logic signed [DW-1:0] sat16(input logic signed [AW-1:0] v);
    if (v > POS_LIM) return {1'b0, {(DW-1){1'b1}}};
    if (v < NEG_LIM) return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction
`endif

  always_comb begin
    st      = phase_of(ph_q);
    tap     = 3'(ph_q - PH_MAC_FIRST);
    tap_mir = 4'(DL_LEN - 1) - {1'b0, tap};
    ph_d    = ph_q + PH_W'(1);
    dl_d    = dl_q;
    res_d   = res_q;
    dout_d  = dout_q;
    en200_d = 1'b0;
    if (st == ST_LOAD) begin
      for (int k = DL_LEN - 1; k > 0; k--) dl_d[k] = dl_q[k-1];
      dl_d[0] = din;
    end
`ifdef HB_SAT_EN
    rnd   = rnd_shift(acc);
    sat_d = (st == ST_ROUND) && is_clip(rnd);
    if (st == ST_ROUND) res_d = sat16(rnd);
`else
    if (st == ST_ROUND) res_d = DW'(rnd_shift(acc));
`endif
    // Two output slots per frame: centre-tap branch mid-frame, FIR branch at frame end.
    if (ph_q == PH_OUT_A) begin
      dout_d  = dl_q[CTR_TAP];
      en200_d = 1'b1;
    end else if (ph_q == PH_OUT_B) begin
      dout_d  = res_q;
      en200_d = 1'b1;
    end
  end

  hb_mac u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (st == ST_LOAD),
    .en   (st == ST_MAC),
    .a    (dl_q[{1'b0, tap}]),
    .b    (dl_q[tap_mir]),
    .coef (HB_COEF[tap]),
    .acc  (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q    <= '0;
      dl_q    <= '{default: '0};
      res_q   <= '0;
      dout_q  <= '0;
      en200_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      dl_q    <= dl_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      en200_q <= en200_d;
    end
  end

`ifdef HB_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`endif

  // Gated by rst so the strobe stays low while the chain is held in reset.
  assign en_100k = (ph_q == PH_LOAD) && !rst;
  assign dout    = dout_q;
  assign en_200k = en200_q;

endmodule

// File: tb/tb_hb_interp2_stage2.sv
// Scoreboard bench for hb_interp2_stage2: convolution reference model feeds an expectation
// queue, an independent negedge monitor checks strobes and every output sample.
module tb_hb_interp2_stage2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] din = '0;
  logic               en_100k;
  logic signed [15:0] dout;
  logic               en_200k;
`ifdef HB_SAT_EN
  logic               sat_flag;
`endif

  hb_interp2_stage2 dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .en_100k  (en_100k),
    .dout     (dout),
    .en_200k  (en_200k)
`ifdef HB_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  localparam int HC [8] = '{-24, 74, -180, 376, -718, 1321, -2560, 18095};

  int                 total = 0;
  int                 bad   = 0;
  int                 cyc   = 0;
  logic               last_clip = 1'b0;
  logic signed [15:0] xs [$];
  logic signed [15:0] exp_q [$];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    xs.delete();
    repeat (16) xs.push_back(16'sd0);
    exp_q.delete();
    last_clip = 1'b0;
  endtask

  // Frame model: centre tap is the input 7 frames back; FIR is the 16-tap mirrored convolution.
  task automatic model_push(input logic signed [15:0] x);
    longint             acc;
    longint             r;
    logic signed [15:0] e;
    logic               clip;
    xs.push_front(x);
    void'(xs.pop_back());
    acc = 0;
    for (int j = 0; j < 16; j++)
      acc += longint'(HC[(j < 8) ? j : 15 - j]) * longint'(xs[j]);
    r    = (acc + 64'sd16384) >>> 15;
    clip = 1'b0;
`ifdef HB_SAT_EN
    if (r > 32767) begin
      e = 16'sd32767; clip = 1'b1;
    end else if (r < -32768) begin
      e = -16'sd32768; clip = 1'b1;
    end else begin
      e = 16'(r);
    end
`else
    e = 16'(r);
`endif
    exp_q.push_back(xs[7]);
    exp_q.push_back(e);
    last_clip = clip;
  endtask

  // mode: 0 DC, 1 impulse then zeros, 2 full-scale alternating with a flip every 8, 3 random
  task automatic run_frames(input int n, input int mode);
    int                 w;
    logic signed [15:0] x;
    for (int i = 0; i < n; i++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!en_100k && w < 64);
      if (!en_100k) begin
        total++; bad++;
        $display("FAIL en_100k_timeout: got none within %0d cycles want a strobe", w);
        return;
      end
      case (mode)
        0:       x = 16'sd1000;
        1:       x = (i == 0) ? 16'sd16384 : 16'sd0;
        2:       x = (((i ^ (i >> 3)) & 1) != 0) ? 16'sd32767 : -16'sd32768;
        default: x = 16'($urandom);
      endcase
      din = x;
      model_push(x);
    end
  endtask

  always @(negedge clk) begin
    logic signed [15:0] e;
    if (rst) begin
      chk("rst_dout", dout, 0);
      chk("rst_en_200k", en_200k, 0);
      chk("rst_en_100k", en_100k, 0);
      cyc = 0;
    end else begin
      chk("en_100k", en_100k, ((cyc % 32) == 0));
      chk("en_200k", en_200k, ((cyc > 0) && ((cyc % 16) == 0)));
      if (en_200k) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dout_unexpected: got sample %0d want no output", dout);
        end else begin
          e = exp_q.pop_front();
          chk("dout", dout, e);
        end
      end
`ifdef HB_SAT_EN
      chk("sat_flag", sat_flag, (((cyc % 32) == 10) && last_clip));
`endif
      cyc++;
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;

    run_frames(10, 0);
    run_frames(17, 1);
    run_frames(24, 2);
    run_frames(40, 3);

    // Abort a frame mid-MAC: the last run_frames returns on the ph==0 cycle.
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("async_dout", dout, 0);
    chk("async_en_200k", en_200k, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    run_frames(2000, 3);
    repeat (34) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
